// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: responder read port, redirect request and decode handshake.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline/memory.
interface instr_fetch_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_addr_out;
  logic        mem_read_valid;
  logic        mem_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output mem_addr,
    input  mem_dout,
    input  mem_addr_out,
    input  mem_read_valid,
    input  mem_ready,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    input  mem_addr,
    output mem_dout,
    output mem_addr_out,
    output mem_read_valid,
    output mem_ready,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch initiator: walks the PC, accepts only responses whose echoed address
// matches the current PC, and buffers {pc, instr} pairs in a small FIFO for decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  input logic           enable,
  instr_fetch_if.master bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0] data_mem [FIFO_DEPTH];
  logic [31:0] pc_mem   [FIFO_DEPTH];

  logic full;
  logic pop;
  logic push;
  logic addr_match;

  // Low address bits carry no information for word-aligned fetch.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.mem_addr_out[1:0], bus.redirect_pc[1:0]};

  assign full       = (count_q == CntW'(FIFO_DEPTH));
  assign addr_match = (bus.mem_addr_out[31:2] == pc_q[31:2]);
  assign pop        = bus.instr_valid & bus.instr_ready & ~bus.redirect_valid;
  // Push is also the capture: mismatched echoes (stale or latent data) are simply dropped.
  assign push       = (state_q == StFetch) & bus.mem_ready & bus.mem_read_valid & addr_match &
                      (~full | pop) & ~bus.redirect_valid;

  assign bus.mem_addr    = pc_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = data_mem[rd_ptr_q];
  assign bus.instr_pc    = pc_mem[rd_ptr_q];

  // FSM next state: fetch runs while enabled; redirects never change state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable)  state_d = StFetch;
      StFetch: if (!enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // PC and FIFO bookkeeping; redirect wins over any capture or pop.
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State, PC and FIFO control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; entries need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      data_mem[wr_ptr_q] <= bus.mem_dout;
      pc_mem[wr_ptr_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: directed scenarios push expected {pc, instr} pairs,
// a monitor pops and compares every accepted decode handshake.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic rsp_ready = 1'b0;
  logic rsp_valid = 1'b0;
  logic rsp_bad = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom = 32'h3701_0080;
      32'h0000_0004: rom = 32'h9300_1002;
      32'h0000_0008: rom = 32'h9300_2002;
      32'h0000_0028: rom = 32'h8320_4100;
      default:       rom = a ^ 32'hC0DE_0013;
    endcase
  endfunction

  // Responder: echoes the request address, or a wrong one when rsp_bad is set.
  assign bus.mem_addr_out   = rsp_bad ? (bus.mem_addr + 32'h100) : bus.mem_addr;
  assign bus.mem_dout       = rom(bus.mem_addr_out);
  assign bus.mem_ready      = rsp_ready;
  assign bus.mem_read_valid = rsp_valid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc);
    exp_q.push_back({pc, rom(pc)});
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    enable             = 1'b0;
    rsp_ready          = 1'b1;
    rsp_valid          = 1'b1;
    rsp_bad            = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    tick();
    tick();
    chk("reset_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("reset_addr", bus.mem_addr, 32'h0000_0000);
  endtask

  // Monitor: every accepted, non-killed head must match the next expected entry.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h expected no entry",
                 bus.instr_pc, bus.instr);
      end else begin
        e = exp_q.pop_front();
        if ({bus.instr_pc, bus.instr} !== e) begin
          errors++;
          $display("FAIL pop_data: got pc=%h instr=%h expected pc=%h instr=%h",
                   bus.instr_pc, bus.instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Zero-latency stream of three words, then stop responses and idle.
    do_reset();
    expect_entry(32'h0);
    expect_entry(32'h4);
    expect_entry(32'h8);
    rst_n = 1'b1;
    enable = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    chk("t1_valid_edge0", {31'h0, bus.instr_valid}, 32'h0);
    tick();
    chk("t1_pc0", bus.instr_pc, 32'h0);
    chk("t1_word0", bus.instr, 32'h3701_0080);
    tick();
    chk("t1_pc1", bus.instr_pc, 32'h4);
    chk("t1_word1", bus.instr, 32'h9300_1002);
    tick();
    rsp_valid = 1'b0;
    chk("t1_pc2", bus.instr_pc, 32'h8);
    chk("t1_word2", bus.instr, 32'h9300_2002);
    tick();
    tick();
    chk("t1_drained", {31'h0, bus.instr_valid}, 32'h0);
    chk("t1_addr", bus.mem_addr, 32'hC);
    enable = 1'b0;
    tick();
    tick();
    rsp_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("en_hold_addr", bus.mem_addr, 32'hC);
    chk("en_hold_valid", {31'h0, bus.instr_valid}, 32'h0);

    // Decode stalled: FIFO fills to depth, then drains with no gaps.
    do_reset();
    for (int i = 0; i < 5; i++) expect_entry(32'(i * 4));
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("t2_stall_addr", bus.mem_addr, 32'h10);
    chk("t2_head_pc", bus.instr_pc, 32'h0);
    tick();
    chk("t2_stall_addr2", bus.mem_addr, 32'h10);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_drain_valid", {31'h0, bus.instr_valid}, 32'h1);
      chk("t2_drain_pc", bus.instr_pc, 32'(i * 4));
      tick();
      if (i == 0) begin
        rsp_valid = 1'b0;
        chk("t2_addr_after_full_push", bus.mem_addr, 32'h14);
      end
    end
    chk("t2_empty", {31'h0, bus.instr_valid}, 32'h0);

    // Redirect with three buffered entries: old entries vanish.
    do_reset();
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t3_addr_before", bus.mem_addr, 32'hC);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h2B;
    bus.instr_ready = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t3_flushed", {31'h0, bus.instr_valid}, 32'h0);
    chk("t3_new_addr", bus.mem_addr, 32'h28);
    expect_entry(32'h28);
    expect_entry(32'h2C);
    tick();
    chk("t3_head_pc", bus.instr_pc, 32'h28);
    chk("t3_head_word", bus.instr, 32'h8320_4100);
    tick();
    rsp_valid = 1'b0;
    tick();
    chk("t3_empty", {31'h0, bus.instr_valid}, 32'h0);

    // Mismatched echoes are discarded until the address matches.
    do_reset();
    rsp_bad = 1'b1;
    rst_n = 1'b1;
    enable = 1'b1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_addr_held", bus.mem_addr, 32'h0);
    chk("t4_no_push", {31'h0, bus.instr_valid}, 32'h0);
    rsp_bad = 1'b0;
    expect_entry(32'h0);
    tick();
    rsp_valid = 1'b0;
    chk("t4_addr_step", bus.mem_addr, 32'h4);
    chk("t4_head_pc", bus.instr_pc, 32'h0);
    tick();
    chk("t4_single_push", {31'h0, bus.instr_valid}, 32'h0);
    chk("t4_addr_final", bus.mem_addr, 32'h4);

    // Responder not ready, then reset with entries buffered.
    do_reset();
    rsp_ready = 1'b0;
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_addr_held", bus.mem_addr, 32'h0);
    chk("t5_no_push", {31'h0, bus.instr_valid}, 32'h0);
    rsp_ready = 1'b1;
    tick();
    tick();
    rsp_ready = 1'b0;
    chk("t5_two_buffered", {31'h0, bus.instr_valid}, 32'h1);
    chk("t5_addr", bus.mem_addr, 32'h8);
    rst_n = 1'b0;
    tick();
    chk("t5_reset_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("t5_reset_addr", bus.mem_addr, 32'h0);

    // PC wrap at the top of the address space.
    do_reset();
    rsp_valid = 1'b0;
    rst_n = 1'b1;
    enable = 1'b1;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t6_addr_top", bus.mem_addr, 32'hFFFF_FFFC);
    expect_entry(32'hFFFF_FFFC);
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("t6_wrap_addr", bus.mem_addr, 32'h0);
    chk("t6_head_pc", bus.instr_pc, 32'hFFFF_FFFC);
    bus.instr_ready = 1'b1;
    tick();
    chk("t6_empty", {31'h0, bus.instr_valid}, 32'h0);

    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
